// File: rtl/receiver_pkg.sv
// receiver_pkg: shared types and constants for the UART-style serial receiver.
// Holds the receive FSM state encoding, data width and frame slot count,
// plus a small parity helper used by the receiver datapath.
package receiver_pkg;

  localparam int DATA_BITS   = 8;
  localparam int FRAME_SLOTS = 11;  // start + 8 data + parity + stop

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // XOR-reduction of a data byte; matches an even-parity slot when no error.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/receiver_if.sv
// receiver_if: bundles the serial line, control input and received-byte
// outputs of the receiver. slave = receiver side, master = line driver/consumer.
// Ports: rx_data_in, parity_enable (to receiver); rx_data_out, rx_valid,
// parity_error, framing_error, rx_busy (from receiver).
interface receiver_if;
  import receiver_pkg::*;

  logic                 rx_data_in;
  logic                 parity_enable;
  logic [DATA_BITS-1:0] rx_data_out;
  logic                 rx_valid;
  logic                 parity_error;
  logic                 framing_error;
  logic                 rx_busy;

  modport master (
    output rx_data_in, parity_enable,
    input  rx_data_out, rx_valid, parity_error, framing_error, rx_busy
  );

  modport slave (
    input  rx_data_in, parity_enable,
    output rx_data_out, rx_valid, parity_error, framing_error, rx_busy
  );

endinterface

// File: rtl/receiver_sipo.sv
// sipo: serial-in parallel-out shift register, LSB-first serial order.
// Latency: one clk per shift; no backpressure (shift_en is a strobe).
// Ports: clk, rst_n (async active-low), shift_en, data_in, data_out[7:0].
module sipo
  import receiver_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift_en,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] data_out
);

  // Right shift with new bit entering at the MSB: after DATA_BITS shifts
  // the first bit received sits in bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (shift_en) begin
      data_out <= {data_in, data_out[DATA_BITS-1:1]};
    end
  end

endmodule

// File: rtl/receiver.sv
// receiver: serial frame receiver (start, 8 data LSB first, parity slot, stop).
// Latency: rx_valid ~2 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 1 clks after line fall.
// Backpressure: none; rx_valid is a one-cycle pulse, results held until next.
// Ports: clk, rst_n (async active-low), bus (receiver_if.slave).
module receiver
  import receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  receiver_if.slave   bus
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  state_t               state, state_nxt;
  logic                 sync1, sync2;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic                 par_en_q;
  logic                 par_bit;
  logic                 wait_high;
  logic [DATA_BITS-1:0] shift_dat;

  logic start_det, shift_en, par_smp, stop_smp, cnt_clr;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.rx_data_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    shift_en  = 1'b0;
    par_smp   = 1'b0;
    stop_smp  = 1'b0;
    case (state)
      IDLE: begin
        // After a break (stop sampled low) wait for the line to go high
        // before accepting another start edge.
        if (!sync2 && !wait_high) begin
          state_nxt = START;
          start_det = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF_LAST) state_nxt = sync2 ? IDLE : DATA;
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          shift_en = 1'b1;
          if (bit_idx == LAST_BIT) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (cnt == FULL_LAST) begin
          par_smp   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a following start bit with no gap is caught.
        if (cnt == FULL_LAST) begin
          stop_smp  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Restart the bit-time count on every state change and every data sample.
    cnt_clr = (state == IDLE) || (state_nxt != state) || shift_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_idx   <= '0;
      par_en_q  <= 1'b0;
      par_bit   <= 1'b0;
      wait_high <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
      if (start_det)     bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (start_det) par_en_q <= bus.parity_enable;
      if (par_smp)   par_bit  <= sync2;
      if (stop_smp && !sync2)          wait_high <= 1'b1;
      else if (state == IDLE && sync2) wait_high <= 1'b0;
    end
  end

  sipo u_sipo (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .data_in  (sync2),
    .data_out (shift_dat)
  );

  // Results register on the stop-sample edge, so rx_valid is high the
  // cycle after the FSM has already returned to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= stop_smp;
      if (stop_smp) begin
        data_q <= shift_dat;
        perr_q <= par_en_q && (parity_of(shift_dat) != par_bit);
        ferr_q <= !sync2;
      end
    end
  end

  assign bus.rx_data_out   = data_q;
  assign bus.rx_valid      = valid_q;
  assign bus.parity_error  = perr_q;
  assign bus.framing_error = ferr_q;
  assign bus.rx_busy       = (state != IDLE);

endmodule

// File: tb/tb_receiver.sv
// tb_receiver: directed frames against a frame-level model of the receiver.
// Each driven frame pushes its expected byte/flags; a monitor pops on rx_valid.
module tb_receiver;
  import receiver_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  receiver_if bus();

  receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         fall;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         errs = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_perr = 1'b0;
  logic       m_ferr = 1'b0;
  int         n_valid = 0;
  int         valid_cycs[$];
  logic [7:0] cap_data = 8'h00;
  logic       cap_perr = 1'b0;
  logic       cap_ferr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: the model holds the last frame's byte/flags; reset zeroes them
  // and discards any frame in flight.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_data = 8'h00;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      chk("rx_valid_in_reset", {31'd0, bus.rx_valid}, 32'd0);
    end else if (bus.rx_valid === 1'b1) begin
      n_valid++;
      valid_cycs.push_back(cyc);
      cap_data = bus.rx_data_out;
      cap_perr = bus.parity_error;
      cap_ferr = bus.framing_error;
      checks++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_valid: rx_valid=1 at cycle %0d, required no pulse", cyc);
      end else begin
        mon_e  = exp_q.pop_front();
        m_data = mon_e.data;
        m_perr = mon_e.perr;
        m_ferr = mon_e.ferr;
        if (cyc - mon_e.fall < 170 || cyc - mon_e.fall > 172) begin
          errs++;
          $display("FAIL latency: got %0d cycles, required 170..172", cyc - mon_e.fall);
        end
      end
    end
    chk("rx_data_out", {24'd0, bus.rx_data_out}, {24'd0, m_data});
    chk("parity_error", {31'd0, bus.parity_error}, {31'd0, m_perr});
    chk("framing_error", {31'd0, bus.framing_error}, {31'd0, m_ferr});
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pslot, input logic stop,
                          input logic en);
    exp_t e;
    e.data = d;
    e.perr = en && ((^d) != pslot);
    e.ferr = !stop;
    e.fall = cyc;
    exp_q.push_back(e);
  endtask

  // Drives one full frame; flip toggles parity_enable during data bit 4.
  task automatic send_frame(input logic [7:0] d, input logic pslot, input logic stop,
                            input logic en, input logic flip);
    bus.parity_enable = en;
    push_exp(d, pslot, stop, en);
    bus.rx_data_in = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx_data_in = d[i];
      if (flip && i == 4) bus.parity_enable = ~en;
      if (i == 2) chk("busy_mid_frame", {31'd0, bus.rx_busy}, 32'd1);
      wait_cyc(CPB);
    end
    bus.rx_data_in = pslot;
    wait_cyc(CPB);
    bus.rx_data_in = stop;
    wait_cyc(CPB);
  endtask

  task automatic expect_frame(input string name, input int prev_n, input logic [7:0] d,
                              input logic perr, input logic ferr);
    chk({name, "_pulses"}, n_valid, prev_n + 1);
    chk({name, "_data"}, {24'd0, cap_data}, {24'd0, d});
    chk({name, "_perr"}, {31'd0, cap_perr}, {31'd0, perr});
    chk({name, "_ferr"}, {31'd0, cap_ferr}, {31'd0, ferr});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    int idx;
    int k;
    bus.rx_data_in    = 1'b1;
    bus.parity_enable = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    wait_cyc(3);
    chk("reset_busy", {31'd0, bus.rx_busy}, 32'd0);
    chk("reset_data", {24'd0, bus.rx_data_out}, 32'h00);
    chk("reset_valid", {31'd0, bus.rx_valid}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Good frame with parity enabled.
    nv = n_valid;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_frame("a5", nv, 8'hA5, 1'b0, 1'b0);
    wait_cyc(20);
    chk("idle_busy", {31'd0, bus.rx_busy}, 32'd0);

    // Parity error, enable dropped mid-frame must not matter.
    nv = n_valid;
    send_frame(8'hAB, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_frame("ab_en", nv, 8'hAB, 1'b1, 1'b0);
    wait_cyc(20);
    nv = n_valid;
    send_frame(8'hAB, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_frame("ab_dis", nv, 8'hAB, 1'b0, 1'b0);
    wait_cyc(20);

    // Framing error, then a good frame clears the flag.
    nv = n_valid;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_frame("3c_stop0", nv, 8'h3C, 1'b0, 1'b1);
    bus.rx_data_in = 1'b1;
    wait_cyc(20);
    nv = n_valid;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_frame("after_ferr", nv, 8'hA5, 1'b0, 1'b0);
    wait_cyc(20);

    // Short low glitch: false start.
    nv = n_valid;
    bus.rx_data_in = 1'b0;
    wait_cyc(4);
    chk("glitch_busy_high", {31'd0, bus.rx_busy}, 32'd1);
    bus.rx_data_in = 1'b1;
    k = 0;
    while (bus.rx_busy && k < 10) begin
      wait_cyc(1);
      k++;
    end
    chk("glitch_busy_drop", {31'd0, bus.rx_busy}, 32'd0);
    wait_cyc(20);
    chk("glitch_no_valid", n_valid, nv);

    // Reset during data bit 4 of 0xFF.
    nv = n_valid;
    bus.parity_enable = 1'b1;
    push_exp(8'hFF, 1'b0, 1'b1, 1'b1);
    bus.rx_data_in = 1'b0;
    wait_cyc(CPB);
    bus.rx_data_in = 1'b1;
    wait_cyc(4 * CPB + 8);
    rst_n = 1'b0;
    wait_cyc(2);
    chk("midreset_busy", {31'd0, bus.rx_busy}, 32'd0);
    chk("midreset_data", {24'd0, bus.rx_data_out}, 32'h00);
    chk("midreset_ferr", {31'd0, bus.framing_error}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(8 * CPB);
    chk("midreset_no_valid", n_valid, nv);
    send_frame(8'h19, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_frame("19", nv, 8'h19, 1'b0, 1'b0);
    wait_cyc(20);

    // Break: line held low through and beyond a frame.
    nv = n_valid;
    bus.parity_enable = 1'b1;
    push_exp(8'h00, 1'b0, 1'b0, 1'b1);
    bus.rx_data_in = 1'b0;
    wait_cyc(11 * CPB + 100);
    expect_frame("break", nv, 8'h00, 1'b0, 1'b1);
    bus.rx_data_in = 1'b1;
    wait_cyc(20);
    nv = n_valid;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_frame("after_break", nv, 8'hA5, 1'b0, 1'b0);
    wait_cyc(20);

    // Back-to-back frames with no idle gap.
    idx = valid_cycs.size();
    nv = n_valid;
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_frame("b2b_00", nv, 8'h00, 1'b0, 1'b0);
    nv = n_valid;
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_frame("b2b_ff", nv, 8'hFF, 1'b0, 1'b0);
    chk("b2b_count", valid_cycs.size(), idx + 2);
    if (valid_cycs.size() == idx + 2)
      chk("b2b_gap", valid_cycs[idx+1] - valid_cycs[idx], 176);
    wait_cyc(30);
    chk("all_frames_seen", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16; clk cycles per serial bit; even; legal range 4..1024.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 rx_data_in  input  1  serial line; idle high; asynchronous to clk.
REQ-005 parity_enable  input  1  1 = check even parity of received byte; sampled at start detection.
REQ-006 rx_data_out  output  8  last received byte, LSB received first.
REQ-007 rx_valid  output  1  one-cycle pulse; rx_data_out and error flags updated this cycle.
REQ-008 parity_error  output  1  last frame failed parity check.
REQ-009 framing_error  output  1  last frame stop bit sampled 0.
REQ-010 rx_busy  output  1  high from start detection until return to IDLE.

Function
REQ-011 Frame SHALL be 11 bit slots: start (0), 8 data LSB first, parity slot, stop (1); parity slot always present, checked only if parity_enable latched 1.
REQ-012 rx_data_in SHALL pass a 2-flop synchronizer; all logic uses the synchronized bit.
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE: synchronized bit 0 -> START, clear bit counter, latch parity_enable, rx_busy=1.
REQ-015 START: at count CLKS_PER_BIT/2-1 sample; 0 -> DATA with counter restarted; 1 -> IDLE (false start), no rx_valid, flags unchanged.
REQ-016 DATA: every CLKS_PER_BIT cycles sample one bit into shift register (right-shift, MSB-in); after 8th sample -> PARITY.
REQ-017 PARITY: sample after CLKS_PER_BIT cycles; store bit -> STOP.
REQ-018 STOP: sample after CLKS_PER_BIT cycles -> IDLE same edge; next cycle rx_valid=1 with rx_data_out=shifted byte.
REQ-019 parity_error SHALL equal (latched enable) AND (XOR of 8 data bits != parity slot); 0 when disabled.
REQ-020 framing_error SHALL equal NOT(stop sample).
REQ-021 On errors rx_valid SHALL still pulse and rx_data_out still update; flags held until next rx_valid.
REQ-022 Return to IDLE at mid-stop SHALL allow back-to-back frames with zero idle gap.
REQ-023 Latency: rx_valid asserts 2 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 1 cycles (±1) after line falling edge.
REQ-024 Line held low continuously (break): frame completes with framing_error=1, then stays in IDLE until line returns high before new start detection.
REQ-025 parity_enable changes mid-frame SHALL NOT affect current frame.

Reset
REQ-026 rst_n low SHALL force IDLE, synchronizer flops=1, counters=0, shift register=0.
REQ-027 Reset values: rx_data_out=8'h00, rx_valid=0, parity_error=0, framing_error=0, rx_busy=0.
REQ-028 Reset mid-frame SHALL discard partial byte; no rx_valid produced for it.

Structure
REQ-029 Shared package SHALL hold state encoding typedef, DATA_BITS=8, frame slot count=11.
REQ-030 One sub-module sipo (serial-in parallel-out, clk/rst_n/shift_en/data_in/data_out[7:0]), counterpart of existing piso.
REQ-031 Bit-time counter and bit index counter SHALL live in receiver.

Verification (CLKS_PER_BIT=16)
REQ-032 Frame 0xA5, parity slot 0, stop 1, parity_enable=1 -> rx_valid single pulse at ~171 cycles, rx_data_out=0xA5, both errors 0.
REQ-033 Frame 0xAB, parity slot 0, parity_enable=1 -> rx_data_out=0xAB, parity_error=1; repeat with parity_enable=0 -> parity_error=0.
REQ-034 Frame 0x3C with stop slot 0 -> rx_data_out=0x3C, framing_error=1, then next good frame clears flag.
REQ-035 Low glitch of 4 cycles on idle line -> no rx_valid, rx_busy high then 0 within 10 cycles.
REQ-036 rst_n pulsed low during data bit 4 of 0xFF -> all outputs reset values, no rx_valid; following frame 0x19 received correctly.
REQ-037 Back-to-back 0x00 then 0xFF, no idle gap -> two rx_valid pulses 176 cycles apart, values 0x00 then 0xFF, no errors.
